// File: rtl/traffic_car_detector.sv
// Car detector front end for the traffic light controller.
// Each direction (EW, NS) synchronizes its raw loop sensor and debounces it.
// A detected car is latched as a pending request, with a "long wait" flag
// once it has been pending WAIT_LIMIT cycles. A request is dropped when the
// controller shows green for that direction.
module traffic_car_detector #(
  parameter int DEBOUNCE   = 4,
  parameter int WAIT_LIMIT = 16,
  parameter int CNT_W      = 5
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       EWSense,
  input  logic       NSSense,
  input  logic [1:0] EWLite,
  input  logic [1:0] NSLite,
  output logic [1:0] EWCar,
  output logic [1:0] NSCar
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARM    = 2'd1,
    WAIT   = 2'd2,
    SERVED = 2'd3
  } state_e;

  localparam logic [1:0]       LITE_GREEN = 2'b10;
  localparam logic [CNT_W-1:0] CNT_ZERO   = '0;
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] DB_LAST    = CNT_W'(DEBOUNCE - 1);
  localparam logic [CNT_W-1:0] WAIT_MAX   = CNT_W'(WAIT_LIMIT);

  // Index 0 is the EW channel, index 1 is the NS channel.
  logic [1:0]      sense_w;
  logic [1:0][1:0] lite_w;
  logic [1:0][1:0] car_w;

  assign sense_w = {NSSense, EWSense};
  assign lite_w  = {NSLite, EWLite};
  assign EWCar   = car_w[0];
  assign NSCar   = car_w[1];

  for (genvar ch = 0; ch < 2; ch++) begin : g_chan
    logic             s1_q, s2_q;
    logic [CNT_W-1:0] dcnt_q, dcnt_d;
    logic [CNT_W-1:0] wcnt_q, wcnt_d;
    state_e           state_q, state_d;
    logic [1:0]       car_q, car_d;
    logic             green;

    // Only the exact green code counts as green; 2'b11 behaves like red.
    assign green      = (lite_w[ch] == LITE_GREEN);
    assign car_w[ch]  = car_q;

    // Two-flop synchronizer for the asynchronous loop sensor.
    always_ff @(posedge clock) begin
      if (reset) begin
        s1_q <= 1'b0;
        s2_q <= 1'b0;
      end else begin
        s1_q <= sense_w[ch];
        s2_q <= s1_q;
      end
    end

    // Next-state, counter and output decode for the request state machine.
    always_comb begin
      state_d = state_q;
      dcnt_d  = dcnt_q;
      wcnt_d  = wcnt_q;
      car_d   = 2'b00;
      case (state_q)
        IDLE: begin
          // A car seen while already green is served by that green.
          if (s2_q && !green) begin
            state_d = ARM;
            dcnt_d  = CNT_ONE;
          end
        end
        ARM: begin
          if (!s2_q || green) begin
            state_d = IDLE;
            dcnt_d  = CNT_ZERO;
          end else if (dcnt_q == DB_LAST) begin
            state_d = WAIT;
            wcnt_d  = CNT_ZERO;
          end else begin
            dcnt_d = dcnt_q + CNT_ONE;
          end
        end
        WAIT: begin
          // The request is latched: the sensor dropping does not cancel it.
          if (green) begin
            state_d = SERVED;
          end else if (wcnt_q != WAIT_MAX) begin
            wcnt_d = wcnt_q + CNT_ONE;
          end
        end
        SERVED: begin
          // Leaving through IDLE forces a full debounce for any later car.
          if (!green) begin
            state_d = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
      // Outputs are registered from the next state so they move on the
      // same edge as the state transition.
      if (state_d == WAIT) begin
        car_d[0] = 1'b1;
        car_d[1] = (wcnt_d == WAIT_MAX);
      end
    end

    // State, counters and registered request outputs.
    always_ff @(posedge clock) begin
      if (reset) begin
        state_q <= IDLE;
        dcnt_q  <= CNT_ZERO;
        wcnt_q  <= CNT_ZERO;
        car_q   <= 2'b00;
      end else begin
        state_q <= state_d;
        dcnt_q  <= dcnt_d;
        wcnt_q  <= wcnt_d;
        car_q   <= car_d;
      end
    end
  end

endmodule

// File: doc/traffic_car_detector.md
Name: traffic_car_detector

Overview:
Upstream request stage for the traffic light controller. It samples the raw EW and NS vehicle-loop sensors and debounces them. It latches each detected car as a pending request and drives the controller's 2-bit EWCar/NSCar inputs with "car waiting" and "long wait" flags. The controller's EWLite/NSLite outputs feed back into this block, so a request clears once its direction has been served green.

Parameters:
DEBOUNCE, 4, consecutive synchronized-high cycles required to accept a car; legal range >= 2.
WAIT_LIMIT, 16, cycles a request must stay pending before the long-wait flag asserts; legal range >= 1.
CNT_W, 5, width of the debounce and wait counters; must hold max(DEBOUNCE, WAIT_LIMIT).

Ports:
clock  input  1  single system clock; all state updates on posedge.
reset  input  1  synchronous, active-high reset.
EWSense  input  1  raw EW loop sensor, asynchronous to clock.
NSSense  input  1  raw NS loop sensor, asynchronous to clock.
EWLite  input  2  EW light state fed back from the controller.
NSLite  input  2  NS light state fed back from the controller.
EWCar  output  2  EW request to the controller: [0] car waiting, [1] long wait.
NSCar  output  2  NS request to the controller: [0] car waiting, [1] long wait.

Behaviour:
- Interface: one clock (clock); reset is synchronous and active-high (reset). All outputs are registered.
- Light encoding: 2'b00 red, 2'b01 yellow, 2'b10 green. 2'b11 is treated as red.
- Two identical, independent per-direction channels (EW and NS). Each channel has:
  - a 2-flop synchronizer s1 -> s2;
  - a debounce counter dcnt;
  - a wait counter wcnt;
  - a state machine.
- Reset: on any posedge with reset=1:
  - s1 = s2 = 0; dcnt = wcnt = 0; state = IDLE;
  - EWCar = NSCar = 2'b00 after that edge;
  - this applies from any state, including mid-debounce and mid-wait, and reset has priority over every other event.
- IDLE (output 00):
  - if s2=1 and own light != green -> ARM, dcnt = 1;
  - otherwise stay.
  - A car sensed while its light is already green produces no request.
- ARM (output 00):
  - s2=0 or own light == green -> IDLE, dcnt = 0;
  - else if dcnt == DEBOUNCE-1 -> WAIT, wcnt = 0;
  - else dcnt++.
- WAIT (output [0]=1):
  - own light == green -> SERVED;
  - else wcnt increments, saturating at WAIT_LIMIT;
  - [1] = (wcnt == WAIT_LIMIT);
  - s2 dropping does not cancel the request, because the request is latched.
- SERVED (output 00):
  - stay while own light == green;
  - on own light != green -> IDLE.
  - Cars arriving during green are served by that green.
  - A sensor still high after green ends re-arms through IDLE -> ARM; the full debounce is repeated.
- Latency: raw sensor first sampled high at edge k and held high, with own light not green:
  - Car[0] is observed high after edge k+1+DEBOUNCE;
  - Car[1] is observed high WAIT_LIMIT edges after Car[0] rises.
- Clear latency: Car[0] and Car[1] drop after the first edge at which own Lite == 2'b10 is sampled.
- Wait counter: saturates at WAIT_LIMIT, never wraps, and is reset to 0 on each WAIT entry.
- Simultaneous events:
  - the EW and NS channels never interact;
  - both may request at once, and arbitration belongs to the controller.
- Glitch rejection: a sensor pulse shorter than DEBOUNCE cycles at s2 never sets Car[0].

Test Plan:
1. Reset held 2 cycles with sensors high: EWCar = NSCar = 00 throughout and on the edge after release. Debounce then starts fresh, and Car[0] rises after edge release+1+DEBOUNCE.
2. EWSense high from edge k, EWLite = 00, DEBOUNCE = 4: EWCar = 01 after edge k+5. It becomes 11 after edge k+5+16 and stays 11 with EWSense dropped at k+8.
3. NSSense pulsed high for 3 cycles (DEBOUNCE = 4), NSLite = 00: NSCar stays 00. A later 6-cycle pulse sets NSCar = 01 and it stays 01 after the pulse ends.
4. EW pending (EWCar = 11), then EWLite = 10 for 3 cycles and back to 00 with EWSense still high: EWCar = 00 after the first green edge and through green. EWCar returns to 01 DEBOUNCE+1 edges after green ends.
5. EWSense high while EWLite = 10 throughout: EWCar stays 00. Simultaneously NSSense high with NSLite = 00: NSCar = 01 on schedule, with no cross-channel effect.
6. Reset asserted while NSCar = 11: NSCar = 00 after the reset edge, and wcnt restarts from 0 on the next request.
